// File: rtl/clock_pkg.sv
// Shared constants and the 12-hour display mapping for the alarm-clock timekeeper.
package clock_pkg;

    localparam int DEF_SEC_PER_MIN   = 60;
    localparam int DEF_MIN_PER_HOUR  = 60;
    localparam int DEF_HOURS_PER_DAY = 24;

    localparam int DEF_SEC_W = $clog2(DEF_SEC_PER_MIN);
    localparam int DEF_MIN_W = $clog2(DEF_MIN_PER_HOUR);
    localparam int DEF_HR_W  = $clog2(DEF_HOURS_PER_DAY);

    // Wide enough for any hour count the display path is expected to carry
    localparam int DISP_W = 8;

    typedef struct packed {
        logic              pm;
        logic [DISP_W-1:0] disp;
    } disp12_t;

    // Midnight shows as 12 AM, noon as 12 PM, afternoon hours fold back by 12
    function automatic disp12_t to_12h(input logic [DISP_W-1:0] hours);
        disp12_t r;
        r.pm = (hours >= DISP_W'(12));
        if (hours == '0)
            r.disp = DISP_W'(12);
        else if (hours > DISP_W'(12))
            r.disp = hours - DISP_W'(12);
        else
            r.disp = hours;
        return r;
    endfunction

endpackage

// File: rtl/clock_timekeeper_mod_counter.sv
// Modulo-MOD counter with load, clear and increment; wrap flags the MOD-1 -> 0 step.
module mod_counter #(
    parameter int MOD = 60,
    parameter int W   = $clog2(MOD)
) (
    input  logic         clk_1hz,
    input  logic         reset,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         clr,
    output logic [W-1:0] value,
    output logic         wrap
);

    logic at_max;

    assign at_max = (value == W'(MOD - 1));
    assign wrap   = inc && at_max;

    always_ff @(posedge clk_1hz or posedge reset) begin
        if (reset)
            value <= '0;
        else if (load)
            value <= load_val;
        else if (clr)
            value <= '0;
        else if (inc)
            value <= at_max ? '0 : value + W'(1);
    end

endmodule

// File: rtl/clock_timekeeper.sv
// Time-of-day counter: load/adjust/count priority, load validation, carry ticks
// and a combinational 12/24-hour display view.
module clock_timekeeper
    import clock_pkg::*;
#(
    parameter int SEC_PER_MIN   = DEF_SEC_PER_MIN,
    parameter int MIN_PER_HOUR  = DEF_MIN_PER_HOUR,
    parameter int HOURS_PER_DAY = DEF_HOURS_PER_DAY,
    parameter int SEC_W         = $clog2(SEC_PER_MIN),
    parameter int MIN_W         = $clog2(MIN_PER_HOUR),
    parameter int HR_W          = $clog2(HOURS_PER_DAY)
) (
    input  logic             clk_1hz,
    input  logic             reset,
    input  logic             run_en,
    input  logic             mode12,
    input  logic             set_valid,
    input  logic [HR_W-1:0]  set_hours,
    input  logic [MIN_W-1:0] set_minutes,
    input  logic [SEC_W-1:0] set_seconds,
    output logic             set_ack,
    output logic             set_err,
    input  logic             inc_min,
    input  logic             inc_hour,
    output logic [SEC_W-1:0] seconds,
    output logic [MIN_W-1:0] minutes,
    output logic [HR_W-1:0]  hours,
    output logic [HR_W-1:0]  disp_hours,
    output logic             pm,
    output logic             min_tick,
    output logic             hour_tick,
    output logic             day_tick
);

    logic    in_range;
    logic    load;
    logic    adjust;
    logic    count;
    logic    sec_clr;
    logic    min_inc;
    logic    hr_inc;
    logic    sec_wrap;
    logic    min_wrap;
    logic    hr_wrap;
    disp12_t d12;

    assign in_range = (int'(set_hours)   < HOURS_PER_DAY) &&
                      (int'(set_minutes) < MIN_PER_HOUR)  &&
                      (int'(set_seconds) < SEC_PER_MIN);

    // Exactly one of load / adjust / count may act on any edge
    assign load    = set_valid && in_range;
    assign adjust  = !set_valid && (inc_min || inc_hour);
    assign count   = !set_valid && !adjust && run_en;

    assign sec_clr = adjust && inc_min;
    assign min_inc = count ? sec_wrap : (adjust && inc_min);
    assign hr_inc  = count ? min_wrap : (adjust && inc_hour);

    mod_counter #(.MOD(SEC_PER_MIN), .W(SEC_W)) u_sec (
        .clk_1hz  (clk_1hz),
        .reset    (reset),
        .inc      (count),
        .load     (load),
        .load_val (set_seconds),
        .clr      (sec_clr),
        .value    (seconds),
        .wrap     (sec_wrap)
    );

    mod_counter #(.MOD(MIN_PER_HOUR), .W(MIN_W)) u_min (
        .clk_1hz  (clk_1hz),
        .reset    (reset),
        .inc      (min_inc),
        .load     (load),
        .load_val (set_minutes),
        .clr      (1'b0),
        .value    (minutes),
        .wrap     (min_wrap)
    );

    mod_counter #(.MOD(HOURS_PER_DAY), .W(HR_W)) u_hr (
        .clk_1hz  (clk_1hz),
        .reset    (reset),
        .inc      (hr_inc),
        .load     (load),
        .load_val (set_hours),
        .clr      (1'b0),
        .value    (hours),
        .wrap     (hr_wrap)
    );

    // Adjust-edge wraps must not raise ticks, so carries are qualified by count
    always_ff @(posedge clk_1hz or posedge reset) begin
        if (reset) begin
            set_ack   <= 1'b0;
            set_err   <= 1'b0;
            min_tick  <= 1'b0;
            hour_tick <= 1'b0;
            day_tick  <= 1'b0;
        end else begin
            set_ack   <= load;
            set_err   <= set_valid && !in_range;
            min_tick  <= count && sec_wrap;
            hour_tick <= count && min_wrap;
            day_tick  <= count && hr_wrap;
        end
    end

    assign d12 = to_12h(DISP_W'(hours));

    always_comb begin
        disp_hours = hours;
        pm         = 1'b0;
        if (HOURS_PER_DAY == 24) begin
            pm = d12.pm;
            if (mode12)
                disp_hours = HR_W'(d12.disp);
        end
    end

endmodule

// File: tb/tb_clock_timekeeper.sv
// Directed vector table, reset corner sequence and randomized run against a
// seconds-of-day reference model.
module tb_clock_timekeeper;

    localparam int SPM = 60;
    localparam int MPH = 60;
    localparam int HPD = 24;

    logic       clk_1hz = 1'b0;
    logic       reset;
    logic       run_en;
    logic       mode12;
    logic       set_valid;
    logic [4:0] set_hours;
    logic [5:0] set_minutes;
    logic [5:0] set_seconds;
    logic       set_ack;
    logic       set_err;
    logic       inc_min;
    logic       inc_hour;
    logic [5:0] seconds;
    logic [5:0] minutes;
    logic [4:0] hours;
    logic [4:0] disp_hours;
    logic       pm;
    logic       min_tick;
    logic       hour_tick;
    logic       day_tick;

    clock_timekeeper dut (
        .clk_1hz     (clk_1hz),
        .reset       (reset),
        .run_en      (run_en),
        .mode12      (mode12),
        .set_valid   (set_valid),
        .set_hours   (set_hours),
        .set_minutes (set_minutes),
        .set_seconds (set_seconds),
        .set_ack     (set_ack),
        .set_err     (set_err),
        .inc_min     (inc_min),
        .inc_hour    (inc_hour),
        .seconds     (seconds),
        .minutes     (minutes),
        .hours       (hours),
        .disp_hours  (disp_hours),
        .pm          (pm),
        .min_tick    (min_tick),
        .hour_tick   (hour_tick),
        .day_tick    (day_tick)
    );

    always #5 clk_1hz = ~clk_1hz;

    int errors = 0;
    int checks = 0;

    // Reference state: time of day and the registered pulses
    int mh, mm, ms;
    bit mack, merr, mmt, mht, mdt;

    typedef struct {
        bit sv, run, m12, im, ih;
        int sh, smi, ss;
        int eh, em, es;
        bit ack, err, mt, ht, dt;
        int disp;
        bit pm;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input bit sv, input bit run, input bit m12,
                                input bit im, input bit ih,
                                input int sh, input int smi, input int ss,
                                input int eh, input int em, input int es,
                                input bit ack, input bit err, input bit mt,
                                input bit ht, input bit dt,
                                input int disp, input bit p);
        vec_t v;
        v.sv = sv; v.run = run; v.m12 = m12; v.im = im; v.ih = ih;
        v.sh = sh; v.smi = smi; v.ss = ss;
        v.eh = eh; v.em = em; v.es = es;
        v.ack = ack; v.err = err; v.mt = mt; v.ht = ht; v.dt = dt;
        v.disp = disp; v.pm = p;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack_time(input int h, input int m, input int s);
        return {15'd0, 5'(h), 6'(m), 6'(s)};
    endfunction

    function automatic logic [31:0] pack_pulses(input bit a, input bit e, input bit t1,
                                                input bit t2, input bit t3);
        return {27'd0, a, e, t1, t2, t3};
    endfunction

    function automatic logic [31:0] pack_disp(input bit p, input int d);
        return {26'd0, p, 5'(d)};
    endfunction

    task automatic compare_expected(input string tag, input int eh, input int em, input int es,
                                    input bit a, input bit e, input bit t1, input bit t2,
                                    input bit t3, input int d, input bit p);
        check({tag, ".time"},   {15'd0, hours, minutes, seconds}, pack_time(eh, em, es));
        check({tag, ".pulses"}, {27'd0, set_ack, set_err, min_tick, hour_tick, day_tick},
              pack_pulses(a, e, t1, t2, t3));
        check({tag, ".disp"},   {26'd0, pm, disp_hours}, pack_disp(p, d));
    endtask

    function automatic int model_disp();
        if (mode12 === 1'b1) return (mh % 12 == 0) ? 12 : mh % 12;
        return mh;
    endfunction

    task automatic model_reset();
        mh = 0; mm = 0; ms = 0;
        mack = 0; merr = 0; mmt = 0; mht = 0; mdt = 0;
    endtask

    // Advances the reference by one edge using the inputs currently driven
    task automatic model_step();
        int t;
        mack = 0; merr = 0; mmt = 0; mht = 0; mdt = 0;
        if (set_valid) begin
            if (int'(set_hours) < HPD && int'(set_minutes) < MPH && int'(set_seconds) < SPM) begin
                mh = int'(set_hours); mm = int'(set_minutes); ms = int'(set_seconds);
                mack = 1;
            end else begin
                merr = 1;
            end
        end else if (inc_min || inc_hour) begin
            if (inc_min) begin
                mm = (mm + 1) % MPH;
                ms = 0;
            end
            if (inc_hour) mh = (mh + 1) % HPD;
        end else if (run_en) begin
            t = (mh * MPH + mm) * SPM + ms + 1;
            mmt = (t % SPM == 0);
            mht = (t % (SPM * MPH) == 0);
            mdt = (t % (SPM * MPH * HPD) == 0);
            t = t % (SPM * MPH * HPD);
            mh = t / (SPM * MPH);
            mm = (t / SPM) % MPH;
            ms = t % SPM;
        end
    endtask

    task automatic drive(input bit sv, input bit run, input bit m12, input bit im, input bit ih,
                         input int sh, input int smi, input int ss);
        set_valid   = sv;
        run_en      = run;
        mode12      = m12;
        inc_min     = im;
        inc_hour    = ih;
        set_hours   = 5'(sh);
        set_minutes = 6'(smi);
        set_seconds = 6'(ss);
    endtask

    task automatic edge_and_sample();
        model_step();
        @(posedge clk_1hz);
        #1;
    endtask

    task automatic compare_model(input string tag);
        compare_expected(tag, mh, mm, ms, mack, merr, mmt, mht, mdt, model_disp(), mh >= 12);
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 1, 0, 0, 0, 0, 0);
        model_reset();
        #12;
        compare_expected("reset_init", 0, 0, 0, 0, 0, 0, 0, 0, 12, 0);
        @(negedge clk_1hz);
        reset = 1'b0;

        // Reset asserted between edges while counting at 10:20:30
        drive(1, 1, 1, 0, 0, 10, 20, 29);
        edge_and_sample();
        compare_model("pre_reset_load");
        drive(0, 1, 1, 0, 0, 0, 0, 0);
        edge_and_sample();
        compare_expected("pre_reset_count", 10, 20, 30, 0, 0, 0, 0, 0, 10, 0);
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        compare_expected("reset_async", 0, 0, 0, 0, 0, 0, 0, 0, 12, 0);
        @(negedge clk_1hz);
        reset = 1'b0;

        //        sv run m12 im ih  sh smi ss   eh em es  ack err mt ht dt disp pm
        tbl.push_back(mk(1, 1, 1, 0, 0, 23, 59, 58, 23, 59, 58, 1, 0, 0, 0, 0, 11, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0,  0,  0,  0, 23, 59, 59, 0, 0, 0, 0, 0, 11, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0,  0,  0,  0,  0,  0,  0, 0, 0, 1, 1, 1, 12, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0,  0,  0,  0,  0,  0,  1, 0, 0, 0, 0, 0, 12, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 24,  5,  0,  0,  0,  1, 0, 1, 0, 0, 0, 12, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 13, 45, 30, 13, 45, 30, 1, 0, 0, 0, 0,  1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0,  0,  0,  0, 13, 45, 30, 0, 0, 0, 0, 0, 13, 1));
        tbl.push_back(mk(1, 0, 1, 0, 0,  0,  0,  0,  0,  0,  0, 1, 0, 0, 0, 0, 12, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0,  8, 59, 40,  8, 59, 40, 1, 0, 0, 0, 0,  8, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0,  0,  0,  0,  8,  0,  0, 0, 0, 0, 0, 0,  8, 0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 8, 0, 0, 0, 0, 0, 0, 0, 8, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 23, 59, 30, 23, 59, 30, 1, 0, 0, 0, 0, 11, 1));
        tbl.push_back(mk(0, 1, 1, 1, 1,  0,  0,  0,  0,  0,  0, 0, 0, 0, 0, 0, 12, 0));
        tbl.push_back(mk(1, 1, 1, 1, 0,  5,  6,  7,  5,  6,  7, 1, 0, 0, 0, 0,  5, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0,  0,  0,  0,  5,  6,  8, 0, 0, 0, 0, 0,  5, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 12,  0,  0, 12,  0,  0, 1, 0, 0, 0, 0, 12, 1));
        tbl.push_back(mk(1, 1, 1, 0, 0,  5, 60,  0, 12,  0,  0, 0, 1, 0, 0, 0, 12, 1));
        tbl.push_back(mk(1, 1, 1, 0, 0,  5,  0, 60, 12,  0,  0, 0, 1, 0, 0, 0, 12, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0,  0,  0,  0, 12,  0,  1, 0, 0, 0, 0, 0, 12, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 10, 14, 59, 10, 14, 59, 1, 0, 0, 0, 0, 10, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0,  0,  0,  0, 10, 15,  0, 0, 0, 1, 0, 0, 10, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 23, 59, 59, 23, 59, 59, 1, 0, 0, 0, 0, 11, 1));
        tbl.push_back(mk(0, 1, 1, 0, 1,  0,  0,  0,  0, 59, 59, 0, 0, 0, 0, 0, 12, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0,  0,  0,  0,  1,  0,  0, 0, 0, 1, 1, 0,  1, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].sv, tbl[i].run, tbl[i].m12, tbl[i].im, tbl[i].ih,
                  tbl[i].sh, tbl[i].smi, tbl[i].ss);
            edge_and_sample();
            compare_expected($sformatf("vec%0d", i), tbl[i].eh, tbl[i].em, tbl[i].es,
                             tbl[i].ack, tbl[i].err, tbl[i].mt, tbl[i].ht, tbl[i].dt,
                             tbl[i].disp, tbl[i].pm);
        end

        // Randomized phase, seeded near a day boundary to exercise all carries
        drive(1, 1, 1, 0, 0, 23, 58, 50);
        edge_and_sample();
        compare_model("rand_seed");
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 9) == 0,
                  $urandom_range(0, 7) != 0,
                  1'($urandom_range(0, 1)),
                  $urandom_range(0, 14) == 0,
                  $urandom_range(0, 14) == 0,
                  int'($urandom_range(0, 26)),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(55, 63)) : int'($urandom_range(0, 59)),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(50, 63)) : int'($urandom_range(0, 59)));
            edge_and_sample();
            compare_model($sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
